// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD types, constants and helpers
//
// Purpose : common definitions for the BCD counter slice.
// Contents: BCD_MAX    largest legal decimal digit
//           bcd_t      one packed BCD nibble
//           is_bcd()   1 when a nibble holds a legal decimal digit
package bcd_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef logic [3:0] bcd_t;

    function automatic logic is_bcd(input bcd_t n);
        return (n <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one decade cell of the BCD up/down counter
//
// Purpose : holds one decimal digit, steps it up or down, and passes a
//           carry (up) or borrow (down) to the next more significant cell.
// Ports   : clk          system clock, rising edge
//           clrn         asynchronous active-low reset
//           step_in      advance this digit on the next edge
//           up           direction, 1 = increment, 0 = decrement
//           clr          synchronous clear (highest priority)
//           load         synchronous load (beats step_in)
//           load_nibble  value to load; non-decimal nibbles load as 0
//           value        current digit
//           step_out     carry/borrow into the next digit
//           at_term      digit sits at 9 (up) or 0 (down)
module bcd_digit
    import bcd_pkg::*;
(
    input  logic clk,
    input  logic clrn,
    input  logic step_in,
    input  logic up,
    input  logic clr,
    input  logic load,
    input  bcd_t load_nibble,
    output bcd_t value,
    output logic step_out,
    output logic at_term
);

    bcd_t value_q;
    bcd_t value_d;

    assign at_term  = up ? (value_q == BCD_MAX) : (value_q == 4'd0);
    // Carry/borrow only ripples when this digit is itself stepping across its end.
    assign step_out = step_in & at_term;
    assign value    = value_q;

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = 4'd0;
        end else if (load) begin
            value_d = is_bcd(load_nibble) ? load_nibble : 4'd0;
        end else if (step_in) begin
            if (at_term) begin
                value_d = up ? 4'd0 : BCD_MAX;
            end else begin
                value_d = up ? (value_q + 4'd1) : (value_q - 4'd1);
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            value_q <= 4'd0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/bcd_counter_display.sv
// rtl/bcd_counter_display.sv - prescaled multi-digit BCD up/down counter for 7-segment display
//
// Purpose : counts in decimal once every PRESCALE enabled clocks and presents
//           one BCD nibble per display digit to the downstream decoders.
// Config  : define BCD_LEADING_ZERO_BLANK_EN to drive blank[] for leading
//           zeros; otherwise blank is constant 0.
// Ports   : clk       system clock, rising edge
//           clrn      asynchronous active-low reset
//           en        run enable; prescaler and counter hold when low
//           up        direction, 1 = increment, 0 = decrement
//           load      synchronous load strobe
//           load_val  BCD value to load, digit0 in [3:0]
//           clr       synchronous clear strobe (beats load)
//           digits    current BCD count, digit0 in [3:0]
//           tick      prescaler step pulse (combinational)
//           wrap      terminal-count pulse (combinational)
//           blank     per-digit blank request
module bcd_counter_display
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 500000
) (
    input  logic                  clk,
    input  logic                  clrn,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  clr,
    output logic [4*DIGITS-1:0]   digits,
    output logic                  tick,
    output logic                  wrap,
    output logic [DIGITS-1:0]     blank
);

    localparam int             PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PS_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]     ps_q;
    logic [PW-1:0]     ps_d;
    logic [DIGITS:0]   step;
    logic [DIGITS-1:0] term;

    assign tick = en && (ps_q == PS_LAST);

    // Clear and load both restart the step interval from a fresh phase.
    always_comb begin
        ps_d = ps_q;
        if (clr || load) begin
            ps_d = '0;
        end else if (tick) begin
            ps_d = '0;
        end else if (en) begin
            ps_d = ps_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end

    assign step[0] = tick;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk         (clk),
            .clrn        (clrn),
            .step_in     (step[g]),
            .up          (up),
            .clr         (clr),
            .load        (load),
            .load_nibble (load_val[4*g +: 4]),
            .value       (digits[4*g +: 4]),
            .step_out    (step[g+1]),
            .at_term     (term[g])
        );
    end

    // The top carry-out already means tick with every digit terminal; the
    // explicit terminal AND keeps wrap tied to the digit values themselves.
    assign wrap = step[DIGITS] & (&term);

`ifdef BCD_LEADING_ZERO_BLANK_EN
    for (genvar i = 0; i < DIGITS; i++) begin : g_blank
        if (i == 0) begin : g_units
            // The units digit always shows, so a zero count reads "0".
            assign blank[0] = 1'b0;
        end else begin : g_upper
            assign blank[i] = (digits[4*DIGITS-1 : 4*i] == '0);
        end
    end
`else
    assign blank = '0;
`endif

endmodule

// File: doc/bcd_counter_display.md
Name: bcd_counter_display

Overview:
- Multi-digit decimal (BCD) up/down counter driven by an internal prescaler.
- Produces one packed 4-bit BCD nibble per display digit.
- Sits directly upstream of the per-digit 7-segment decoders; each nibble feeds one decoder_7seg instance on a static HEX display.
- Used for stopwatch/counter experiments on the 50 MHz board clock.

Parameters:
- DIGITS, 4, number of BCD digits (1..6).
- PRESCALE, 500000, clk cycles per count step (>=1); default gives 100 Hz at 50 MHz.

Ports:
- clk  in  1  system clock, rising edge.
- clrn  in  1  asynchronous active-low reset.
- en  in  1  run enable, level; prescaler and counter hold when 0.
- up  in  1  direction; 1 = increment, 0 = decrement.
- load  in  1  synchronous load strobe.
- load_val  in  4*DIGITS  BCD value to load; digit0 in [3:0].
- clr  in  1  synchronous clear strobe.
- digits  out  4*DIGITS  current BCD count; digit0 in [3:0]; feeds the decoders.
- tick  out  1  prescaler step pulse.
- wrap  out  1  terminal-count pulse.
- blank  out  DIGITS  per-digit blank request to the display stage.

Behaviour:
- Reset: clrn=0 asynchronously forces digits=0, prescaler=0, tick=0, wrap=0, blank=0. No clock edge is required.
- Reset mid-count discards the prescaler phase. Counting restarts from 0 after release.
- Prescaler:
  - Counts 0..PRESCALE-1 while en=1 and holds while en=0.
  - Width is max(1, $clog2(PRESCALE)).
  - tick = en && (prescaler == PRESCALE-1), combinational. The prescaler returns to 0 on that edge.
  - With PRESCALE=1, tick is high every cycle that en=1.
- Count step: on a clock edge where tick=1, digits advance by one in the direction of up.
  - The new value is visible the cycle after tick.
  - up is sampled on the tick edge only.
- Decade arithmetic:
  - Up: a digit at 9 goes to 0 and carries into the next digit.
  - Down: a digit at 0 goes to 9 and borrows from the next digit.
  - No digit ever holds a value above 9.
- Wrap:
  - wrap = tick && (up ? all digits 9 : all digits 0), combinational, one cycle.
  - Up from 99..9 gives 00..0. Down from 00..0 gives 99..9.
- Priority on a single edge: clr > load > tick step.
  - clr: digits=0, prescaler=0.
  - load: digits=load_val, prescaler=0.
  - tick and wrap are still computed from pre-edge state, but their step is suppressed.
- Invalid load: any load_val nibble greater than 9 loads as 0; the other nibbles load normally.
- en low between tick and edge: tick is already 0, so no step occurs.
- blank: tied to 0 unless the optional feature is enabled.

Optional Feature:
- Macro: BCD_LEADING_ZERO_BLANK_EN.
- Defined:
  - blank[i]=1 when digit i and every higher digit are 0, for i >= 1.
  - blank[0] is always 0, so a zero count shows one "0".
  - blank is combinational from the digits register.
- Undefined: blank = 0 constant. No extra logic is generated.

Decomposition:
- Package bcd_pkg contains:
  - localparam BCD_MAX = 4'd9.
  - typedef logic [3:0] bcd_t.
  - function is_bcd(bcd_t).
- Sub-module bcd_digit: one decade cell.
  - Inputs: clk, clrn, step_in, up, clr, load, load_nibble.
  - Outputs: value, step_out (carry/borrow), at_term.
  - DIGITS instances are chained through step_out -> step_in.
- The top level holds the prescaler, wrap, and blank logic.

Test Plan (DIGITS=4, PRESCALE=4):
- Reset and hold: clrn=0 mid-run, checked between clock edges -> digits=0000, tick=0, wrap=0 immediately. Release with en=0 for 20 cycles -> digits stay 0000 and tick never asserts.
- Count up and hold: en=1, up=1, 40 cycles -> tick every 4th cycle; digits=0010. Drop en for 10 cycles -> digits hold 0010 and the prescaler phase is kept.
- Up wrap: load 9999, up=1 -> next tick shows wrap=1 for exactly one cycle, then digits=0000.
- Down wrap and borrow: load 0000, up=0 -> wrap=1 on the next tick, digits=9999; next step -> 9998. Load 0100 and step down -> 0099.
- Invalid load and priority:
  - load_val=0x12A4 -> digits=1204.
  - clr and load together with load_val=5555 -> digits=0000.
  - load and tick together -> loaded value wins, no step.
- Optional macro defined:
  - digits=0042 -> blank=1100.
  - digits=0000 -> blank=1110.
  - digits=1000 -> blank=0000.
- Optional macro undefined: blank=0000 in all cases.
